// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the button event classifier.
// Holds the gesture FSM state encoding and the ms-to-cycles conversion.
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    SECOND    = 3'd4
  } btn_state_e;

  // 64-bit arithmetic so large clock rates times long durations cannot overflow.
  function automatic longint unsigned ms_to_cycles(input longint unsigned freq_hz,
                                                   input longint unsigned ms);
    return (freq_hz * ms) / 64'd1000;
  endfunction

endpackage

// File: rtl/event_timer.sv
// Saturating cycle timer with synchronous clear and an equality compare against a
// caller-selected terminal value.
module event_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic             hit_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Clear has priority; the count holds at all-ones instead of wrapping.
  always_comb begin
    count_next = count_reg;
    if (clear_i) begin
      count_next = '0;
    end else if (enable_i && (count_reg != '1)) begin
      count_next = count_reg + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign hit_o = (count_reg == terminal_i);

endmodule

// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into press/release edges and short, long
// and double-click gestures; every output is a registered single-cycle pulse.
module button_event_classifier
  import btn_event_pkg::*;
#(
  parameter int unsigned WIDTH_COUNTER   = 24,
  parameter int unsigned CLOCK_FREQ      = 10_000_000,
  parameter int unsigned LONG_PRESS_MS   = 1000,
  parameter int unsigned DOUBLE_CLICK_MS = 300
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic debounced_i,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic double_o
);

  localparam longint unsigned LONG_CYCLES = ms_to_cycles(64'(CLOCK_FREQ), 64'(LONG_PRESS_MS));
  localparam longint unsigned GAP_CYCLES  = ms_to_cycles(64'(CLOCK_FREQ), 64'(DOUBLE_CLICK_MS));
  localparam longint unsigned COUNT_MAX   = (64'd1 << WIDTH_COUNTER) - 64'd1;

  generate
    if ((LONG_CYCLES < 64'd2) || (GAP_CYCLES < 64'd2) ||
        (LONG_CYCLES > COUNT_MAX) || (GAP_CYCLES > COUNT_MAX)) begin : gen_bad_params
      $error("button_event_classifier: timing constants must be >= 2 and fit WIDTH_COUNTER");
    end
  endgenerate

  localparam logic [WIDTH_COUNTER-1:0] LONG_TERM = WIDTH_COUNTER'(LONG_CYCLES - 64'd1);
  localparam logic [WIDTH_COUNTER-1:0] GAP_TERM  = WIDTH_COUNTER'(GAP_CYCLES - 64'd1);

  logic       prev_reg;
  logic       rise;
  logic       fall;
  btn_state_e state_reg;
  btn_state_e state_next;
  logic       timer_clear;
  logic       timer_hit;
  logic [WIDTH_COUNTER-1:0] timer_terminal;

  logic press_reg, release_reg, short_reg, long_reg, double_reg;
  logic short_next, long_next, double_next;

  assign rise = debounced_i & ~prev_reg;
  assign fall = ~debounced_i & prev_reg;

  // Only GAP waits on the release window; every other timed state waits on the hold time.
  assign timer_terminal = (state_reg == GAP) ? GAP_TERM : LONG_TERM;
  assign timer_clear    = (state_next != state_reg);

  event_timer #(
    .WIDTH (WIDTH_COUNTER)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (timer_clear),
    .enable_i   (1'b1),
    .terminal_i (timer_terminal),
    .hit_o      (timer_hit)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Edges are tested before timeouts so a coincident edge always wins.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (rise) state_next = PRESSED;
      PRESSED:   if (fall) state_next = GAP;
                 else if (timer_hit) state_next = LONG_HELD;
      LONG_HELD: if (fall) state_next = IDLE;
      GAP:       if (rise) state_next = SECOND;
                 else if (timer_hit) state_next = IDLE;
      SECOND:    if (fall) state_next = IDLE;
                 else if (timer_hit) state_next = LONG_HELD;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    unique case (state_reg)
      PRESSED: long_next = ~fall & timer_hit;
      GAP:     short_next = ~rise & timer_hit;
      SECOND: begin
        double_next = fall;
        long_next   = ~fall & timer_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_reg    <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      short_reg   <= 1'b0;
      long_reg    <= 1'b0;
      double_reg  <= 1'b0;
    end else begin
      prev_reg    <= debounced_i;
      press_reg   <= rise;
      release_reg <= fall;
      short_reg   <= short_next;
      long_reg    <= long_next;
      double_reg  <= double_next;
    end
  end

  assign press_o   = press_reg;
  assign release_o = release_reg;
  assign short_o   = short_reg;
  assign long_o    = long_reg;
  assign double_o  = double_reg;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with LONG_CYCLES=10, GAP_CYCLES=5.
module tb_button_event_classifier;

  logic clk_i = 1'b0;
  logic reset_i;
  logic debounced_i;
  logic press_o, release_o, short_o, long_o, double_o;

  button_event_classifier #(
    .WIDTH_COUNTER   (8),
    .CLOCK_FREQ      (1000),
    .LONG_PRESS_MS   (10),
    .DOUBLE_CLICK_MS (5)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .debounced_i (debounced_i),
    .press_o     (press_o),
    .release_o   (release_o),
    .short_o     (short_o),
    .long_o      (long_o),
    .double_o    (double_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int P = 0, R = 1, S = 2, L = 3, D = 4;

  logic [4:0] outs;
  assign outs = {double_o, long_o, short_o, release_o, press_o};

  int cyc = 0;
  int cnt [5];
  int last_cyc [5];
  int base [5];
  int multi_hot = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Counts every cycle an output is high, so a stretched pulse shows up as an extra count.
  always @(negedge clk_i) begin
    for (int i = 0; i < 5; i++) begin
      if (outs[i]) begin
        cnt[i]++;
        last_cyc[i] = cyc;
      end
    end
    if ($countones(outs[4:2]) > 1) multi_hot++;
  end

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    debounced_i = lvl;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 5; i++) base[i] = cnt[i];
  endtask

  function automatic int delta(input int idx);
    return cnt[idx] - base[idx];
  endfunction

  int rc, fc, f2;

  initial begin
    for (int i = 0; i < 5; i++) begin
      cnt[i] = 0;
      last_cyc[i] = -1;
      base[i] = 0;
    end
    reset_i = 1'b1;
    debounced_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("reset_outs", int'(outs), 0);
    reset_i = 1'b0;
    hold(1'b0, 5);
    check_eq("idle_no_pulse", cnt[P] + cnt[R] + cnt[S] + cnt[L] + cnt[D], 0);

    // Short click: 3 high, 20 low.
    snap();
    rc = cyc;
    hold(1'b1, 3);
    fc = cyc;
    hold(1'b0, 20);
    check_eq("short_press_cnt", delta(P), 1);
    check_eq("short_press_cyc", last_cyc[P], rc + 1);
    check_eq("short_release_cnt", delta(R), 1);
    check_eq("short_release_cyc", last_cyc[R], fc + 1);
    check_eq("short_cnt", delta(S), 1);
    check_eq("short_cyc", last_cyc[S], fc + 6);
    check_eq("short_no_long", delta(L), 0);
    check_eq("short_no_double", delta(D), 0);

    // Long press: 15 high, then release.
    snap();
    rc = cyc;
    hold(1'b1, 15);
    check_eq("long_cnt", delta(L), 1);
    check_eq("long_cyc", last_cyc[L], rc + 11);
    snap();
    hold(1'b0, 20);
    check_eq("long_rel_release", delta(R), 1);
    check_eq("long_rel_short", delta(S), 0);
    check_eq("long_rel_long", delta(L), 0);
    check_eq("long_rel_double", delta(D), 0);

    // Double click: 3 high, 2 low, 3 high, low.
    snap();
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 3);
    f2 = cyc;
    hold(1'b0, 20);
    check_eq("dbl_cnt", delta(D), 1);
    check_eq("dbl_cyc", last_cyc[D], f2 + 1);
    check_eq("dbl_press_cnt", delta(P), 2);
    check_eq("dbl_release_cnt", delta(R), 2);
    check_eq("dbl_no_short", delta(S), 0);
    check_eq("dbl_no_long", delta(L), 0);

    // Rise exactly when the GAP timer reads 4: still a double click.
    snap();
    hold(1'b1, 3);
    hold(1'b0, 5);
    hold(1'b1, 3);
    hold(1'b0, 20);
    check_eq("gap_edge_double", delta(D), 1);
    check_eq("gap_edge_no_short", delta(S), 0);

    // Fall when the PRESSED timer reads 9: short, not long.
    snap();
    rc = cyc;
    hold(1'b1, 10);
    fc = cyc;
    hold(1'b0, 20);
    check_eq("hold10_no_long", delta(L), 0);
    check_eq("hold10_short", delta(S), 1);
    check_eq("hold10_short_cyc", last_cyc[S], fc + 6);

    // One cycle longer crosses into a long press.
    snap();
    rc = cyc;
    hold(1'b1, 11);
    hold(1'b0, 20);
    check_eq("hold11_long", delta(L), 1);
    check_eq("hold11_long_cyc", last_cyc[L], rc + 11);
    check_eq("hold11_no_short", delta(S), 0);

    // Reset while in GAP, level rising during reset.
    snap();
    hold(1'b1, 3);
    hold(1'b0, 2);
    reset_i = 1'b1;
    hold(1'b0, 3);
    check_eq("rst_gap_outs", int'(outs), 0);
    hold(1'b1, 2);
    check_eq("rst_high_outs", int'(outs), 0);
    check_eq("rst_no_short", delta(S), 0);
    check_eq("rst_press_before", delta(P), 1);
    reset_i = 1'b0;
    rc = cyc;
    hold(1'b1, 3);
    fc = cyc;
    hold(1'b0, 20);
    check_eq("rst_press_after", delta(P), 2);
    check_eq("rst_press_cyc", last_cyc[P], rc + 1);
    check_eq("rst_short_after", delta(S), 1);
    check_eq("rst_short_cyc", last_cyc[S], fc + 6);
    check_eq("rst_no_double", delta(D), 0);

    check_eq("one_hot_class", multi_hot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_classifier.md
BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 Parameter WIDTH_COUNTER, default 24, SHALL set the width of the internal hold/gap timer.
REQ-002 Parameter CLOCK_FREQ, default 10_000_000, SHALL give the clk_i frequency in Hz.
REQ-003 Parameter LONG_PRESS_MS, default 1000, SHALL give the hold time that qualifies a long press.
REQ-004 Parameter DOUBLE_CLICK_MS, default 300, SHALL give the maximum release gap that still qualifies a double click.
REQ-005 clk_i  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-006 reset_i  input  1  SHALL be the synchronous, active-high reset.
REQ-007 debounced_i  input  1  SHALL carry the debounced switch level, already synchronous to clk_i.
REQ-008 press_o  output  1  SHALL pulse one cycle on each detected rising edge of debounced_i.
REQ-009 release_o  output  1  SHALL pulse one cycle on each detected falling edge of debounced_i.
REQ-010 short_o  output  1  SHALL pulse one cycle when a single short click is classified.
REQ-011 long_o  output  1  SHALL pulse one cycle when a long press is classified.
REQ-012 double_o  output  1  SHALL pulse one cycle when a double click is classified.

Function
REQ-013 LONG_CYCLES SHALL equal CLOCK_FREQ*LONG_PRESS_MS/1000, and GAP_CYCLES SHALL equal CLOCK_FREQ*DOUBLE_CLICK_MS/1000.
REQ-014 Elaboration SHALL fail if either constant is below 2 or does not fit in WIDTH_COUNTER bits.
REQ-015 Edge detection: prev-level register. rise = debounced_i & ~prev; fall = ~debounced_i & prev.
REQ-016 All outputs SHALL be registered; each pulse asserts on the clock edge after its cause cycle and lasts exactly one cycle.
REQ-017 FSM states SHALL be IDLE, PRESSED, LONG_HELD, GAP, SECOND.
REQ-018 Timer SHALL clear on every state change and increment by 1 each cycle otherwise; it SHALL saturate and never wrap.
REQ-019 IDLE: rise -> PRESSED; fall ignored.
REQ-020 PRESSED: fall -> GAP; else timer == LONG_CYCLES-1 -> LONG_HELD with long_o.
REQ-021 LONG_HELD: fall -> IDLE, no classification pulse.
REQ-022 GAP: rise -> SECOND; else timer == GAP_CYCLES-1 -> IDLE with short_o.
REQ-023 SECOND: fall -> IDLE with double_o; else timer == LONG_CYCLES-1 -> LONG_HELD with long_o; the double click is discarded.
REQ-024 An edge and a timeout in the same cycle SHALL resolve in favour of the edge.
REQ-025 press_o/release_o SHALL follow every edge in every state, independent of the FSM.
REQ-026 At most one of short_o, long_o, double_o SHALL be high in any cycle.

Reset
REQ-027 While reset_i is high at a clock edge: FSM -> IDLE, timer -> 0, prev -> 0, all outputs -> 0.
REQ-028 Reset mid-gesture SHALL abandon the gesture with no pulse.
REQ-029 After reset, a level already high SHALL be seen as a rise on the first cycle after reset.

Structure
REQ-030 Package btn_event_pkg SHALL hold the state enum and a function converting ms to cycles.
REQ-031 Sub-module event_timer (clear, enable, saturating count, terminal-compare output) SHALL implement the timer; FSM and edge logic SHALL stay in the top.

Verification
Bench parameters: CLOCK_FREQ=1000, LONG_PRESS_MS=10, DOUBLE_CLICK_MS=5, giving LONG_CYCLES=10 and GAP_CYCLES=5.
REQ-032 Short click: high 3 cycles, then low 20 cycles -> exactly one press_o, one release_o, and one short_o 5 cycles after the fall; no long_o or double_o.
REQ-033 Long press: high 15 cycles -> long_o once, 10 cycles after the rise; on the later release, only release_o.
REQ-034 Double click: high 3, low 2, high 3, low -> double_o once, one cycle after the second fall; no short_o.
REQ-035 Boundary: rise exactly at GAP timer == 4 -> SECOND, no short_o; a fall coinciding with PRESSED timer == 9 -> GAP, not long_o.
REQ-036 Reset: assert reset_i in GAP -> no pulse, all outputs 0; with the level high through reset, the first cycle after reset -> press_o.
